// File: rtl/cla_chain_pkg.sv
// Shared constants and FSM state type for the word-serial CLA chainer.
package cla_chain_pkg;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } chain_state_e;
endpackage

// File: rtl/cla_word_chainer_if.sv
// Operand-in / sum-out valid-ready streams of the chainer.
interface cla_word_chainer_if;
  import cla_chain_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] sum_word;
  logic [IDX_W-1:0]  word_idx;
  logic              last;

  modport master (
    output in_valid, a_word, b_word, out_ready,
    input  in_ready, out_valid, sum_word, word_idx, last
  );

  modport slave (
    input  in_valid, a_word, b_word, out_ready,
    output in_ready, out_valid, sum_word, word_idx, last
  );
endinterface

// File: rtl/cla_adder16.sv
// 16-bit two-level carry-lookahead adder (4-bit groups), purely combinational.
module cla_adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
    end
    // group carries resolved in parallel from group generate/propagate
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (int unsigned i = 0; i < 4; i++) begin
      c[4*i]   = gc[i];
      c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];
endmodule

// File: rtl/cla_word_chainer.sv
// Multi-word adder: streams WORDS operand pairs through one cla_adder16, chaining carry.
// Optional CLA_CHAIN_OVF_EN adds a signed-overflow flag reported with done.
module cla_word_chainer
  import cla_chain_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic carry_in,
  output logic busy,
  output logic carry_out,
  output logic done,
`ifdef CLA_CHAIN_OVF_EN
  output logic overflow,
`endif
  cla_word_chainer_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  chain_state_e      state, state_nxt;
  logic [IDX_W-1:0]  cnt;
  logic              carry_reg;
  logic              in_ready_c;
  logic              accept;
  logic              drain;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;

  cla_adder16 u_adder (
    .a   (bus.a_word),
    .b   (bus.b_word),
    .cin (carry_reg),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        // single output register; refills in the same cycle it drains
        in_ready_c = !bus.out_valid || bus.out_ready;
        if (bus.in_valid && in_ready_c && (cnt == LAST_IDX)) state_nxt = FLUSH;
      end
      FLUSH: if (bus.out_valid && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready = in_ready_c;
  assign accept       = bus.in_valid && in_ready_c;
  assign drain        = bus.out_valid && bus.out_ready;
  assign busy         = (state != IDLE);

`ifdef CLA_CHAIN_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carry_reg     <= 1'b0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.sum_word  <= '0;
      bus.word_idx  <= '0;
      bus.last      <= 1'b0;
      carry_out     <= 1'b0;
      done          <= 1'b0;
`ifdef CLA_CHAIN_OVF_EN
      a_msb         <= 1'b0;
      b_msb         <= 1'b0;
      overflow      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        carry_reg <= carry_in;
        cnt       <= '0;
      end
      if (accept) begin
        bus.sum_word  <= add_sum;
        carry_reg     <= add_cout;
        bus.word_idx  <= cnt;
        bus.last      <= (cnt == LAST_IDX);
        bus.out_valid <= 1'b1;
        cnt           <= cnt + IDX_W'(1);
`ifdef CLA_CHAIN_OVF_EN
        a_msb         <= bus.a_word[WORD_W-1];
        b_msb         <= bus.b_word[WORD_W-1];
`endif
      end else if (drain) begin
        bus.out_valid <= 1'b0;
      end
      if (state == FLUSH && drain) begin
        carry_out <= carry_reg;
        done      <= 1'b1;
`ifdef CLA_CHAIN_OVF_EN
        // carry into MSB recovered as a^b^sum at bit 15; carry out is carry_reg
        overflow  <= a_msb ^ b_msb ^ bus.sum_word[WORD_W-1] ^ carry_reg;
`endif
      end
    end
  end
endmodule
